axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/axi_lite_arbiter_pkg.sv | 18 +
 rtl/axi_lite_rr_pick2.sv | 12 +
 rtl/axi_lite_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and AXI response codes for the two-requester AXI4-Lite arbiter.
package axi_lite_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_rr_pick2.sv
// Two-way round-robin picker: on contention the requester not served last wins.
module axi_lite_rr_pick2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  assign any_valid = |req_valid;
  assign grant     = (&req_valid) ? ~last_grant : req_valid[1];

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates a boot loader and a core MMIO port onto one AXI4-Lite master,
// one transaction in flight, with all master outputs driven from registers.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int AXI_ADDRW      = 32,
  parameter int AXI_DATAW      = 32,
  parameter int AXI_DATAW_BYTE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_we,
  input  logic [2*AXI_ADDRW-1:0]      req_addr,
  input  logic [2*AXI_DATAW-1:0]      req_wdata,
  input  logic [2*AXI_DATAW_BYTE-1:0] req_wstrb,
  output logic [1:0]                  req_done,
  output logic [AXI_DATAW-1:0]        req_rdata,
  output logic [1:0]                  req_resp,
  output logic [AXI_ADDRW-1:0]        araddr,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [AXI_DATAW-1:0]        rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [AXI_ADDRW-1:0]        awaddr,
  output logic [2:0]                  awprot,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATAW-1:0]        wdata,
  output logic [AXI_DATAW_BYTE-1:0]   wstrb,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  arb_state_e state;
  logic       grant_q;
  logic       last_grant;
  logic       pick_grant;
  logic       pick_any;
  logic       wr_complete;

  logic                      sel_we;
  logic [AXI_ADDRW-1:0]      sel_addr;
  logic [AXI_DATAW-1:0]      sel_wdata;
  logic [AXI_DATAW_BYTE-1:0] sel_wstrb;

  assign arprot = 3'b000;
  assign awprot = 3'b000;

  axi_lite_rr_pick2 u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any_valid  (pick_any)
  );

  assign sel_we    = pick_grant ? req_we[1] : req_we[0];
  assign sel_addr  = pick_grant ? req_addr[2*AXI_ADDRW-1:AXI_ADDRW]
                                : req_addr[AXI_ADDRW-1:0];
  assign sel_wdata = pick_grant ? req_wdata[2*AXI_DATAW-1:AXI_DATAW]
                                : req_wdata[AXI_DATAW-1:0];
  assign sel_wstrb = pick_grant ? req_wstrb[2*AXI_DATAW_BYTE-1:AXI_DATAW_BYTE]
                                : req_wstrb[AXI_DATAW_BYTE-1:0];

  // A channel counts as complete once its valid is already low or handshakes now.
  assign wr_complete = (!awvalid || awready) && (!wvalid || wready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      req_done   <= 2'b00;
      req_rdata  <= '0;
      req_resp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_grant;
            if (sel_we) begin
              awaddr  <= sel_addr;
              wdata   <= sel_wdata;
              wstrb   <= sel_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              araddr  <= sel_addr;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            req_rdata <= rdata;
            req_resp  <= rresp;
            req_done  <= {grant_q, ~grant_q};
            state     <= DONE;
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (wr_complete) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            req_rdata <= '0;
            req_resp  <= bresp;
            req_done  <= {grant_q, ~grant_q};
            state     <= DONE;
          end
        end
        DONE: begin
          req_done   <= 2'b00;
          req_rdata  <= '0;
          req_resp   <= RESP_OKAY;
          last_grant <= grant_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench: requesters push expected results from a memory model, a
// monitor pops and compares on every req_done; the slave is a small memory.
`timescale 1ns/1ps
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // requester-side drives, one set per requester
  logic          v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [SW-1:0] s0 = '0, s1 = '0;

  logic [1:0]      req_valid, req_we, req_done, req_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [DW-1:0]   req_rdata;

  assign req_valid = {v1, v0};
  assign req_we    = {we1, we0};
  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};
  assign req_wstrb = {s1, s0};

  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arprot, awprot;
  logic          arvalid, arready, rvalid, rready, awvalid, awready;
  logic          wvalid, wready, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic [SW-1:0] wstrb;

  axi_lite_arbiter #(.AXI_ADDRW(AW), .AXI_DATAW(DW), .AXI_DATAW_BYTE(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Environment memory content before any write; error window is addr[7:4]==F.
  function automatic logic [31:0] env_dflt(input logic [31:0] a);
    return (a[9:2] == 8'd1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
  endfunction
  function automatic bit env_err(input logic [31:0] a);
    return a[7:4] == 4'hF;
  endfunction

  // ---------------- slave ----------------
  bit [31:0] smem [0:255];
  bit        smem_vld [0:255];
  bit        rand_mode = 1'b0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  int ar_rnd = 0, aw_rnd = 0, w_rnd = 0, r_rnd = 0, b_rnd = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_left = 0, b_left = 0;
  int wr_count = 0;
  int r_use, b_use;
  logic [31:0] r_a, aw_a, w_d, wa, wd;
  logic [3:0]  w_s, ws;
  logic        aw_got, w_got, ar_hs, aw_hs, w_hs, wr_fire;
  logic [1:0]  b_r, wr_resp;
  logic [31:0] wr_mask, wr_cur;

  assign arready = arvalid && (ar_cnt >= (rand_mode ? ar_rnd : ar_dly));
  assign awready = awvalid && (aw_cnt >= (rand_mode ? aw_rnd : aw_dly));
  assign wready  = wvalid  && (w_cnt  >= (rand_mode ? w_rnd  : w_dly));
  assign r_use   = rand_mode ? r_rnd : r_dly;
  assign b_use   = rand_mode ? b_rnd : b_dly;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign wa      = aw_hs ? awaddr : aw_a;
  assign wd      = w_hs ? wdata : w_d;
  assign ws      = w_hs ? wstrb : w_s;
  assign wr_resp = env_err(wa) ? RESP_SLVERR : RESP_OKAY;
  assign wr_mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
  assign wr_cur  = smem_vld[wa[9:2]] ? smem[wa[9:2]] : env_dflt(wa);

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (env_err(a)) return 32'h0;
    return smem_vld[a[9:2]] ? smem[a[9:2]] : env_dflt(a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_left <= 0; b_left <= 0;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00; r_a <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; b_r <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        ar_rnd <= $urandom_range(0, 3);
        r_rnd  <= $urandom_range(0, 3);
        r_a    <= araddr;
        if (r_use == 0) begin
          rvalid <= 1'b1; rdata <= slv_rd(araddr); rresp <= env_err(araddr) ? RESP_DECERR : RESP_OKAY;
        end else r_left <= r_use;
      end else if (r_left > 0) begin
        r_left <= r_left - 1;
        if (r_left == 1) begin
          rvalid <= 1'b1; rdata <= slv_rd(r_a); rresp <= env_err(r_a) ? RESP_DECERR : RESP_OKAY;
        end
      end
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; aw_rnd <= $urandom_range(0, 3); end
      if (w_hs) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_rnd <= $urandom_range(0, 3); end
      if (wr_fire) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        wr_count <= wr_count + 1;
        b_rnd <= $urandom_range(0, 3);
        if (!env_err(wa)) begin
          smem[wa[9:2]]     <= (wr_cur & ~wr_mask) | (wd & wr_mask);
          smem_vld[wa[9:2]] <= 1'b1;
        end
        if (b_use == 0) begin bvalid <= 1'b1; bresp <= wr_resp; end
        else begin b_left <= b_use; b_r <= wr_resp; end
      end else if (b_left > 0) begin
        b_left <= b_left - 1;
        if (b_left == 1) begin bvalid <= 1'b1; bresp <= b_r; end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  bit [31:0] rmem [0:255];
  bit        rmem_vld [0:255];

  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    exp_t e;
    logic [31:0] cur;
    int idx;
    idx = int'(a[9:2]);
    cur = rmem_vld[idx] ? rmem[idx] : env_dflt(a);
    e.we = w;
    e.rdata = 32'h0;
    if (w) begin
      if (a[7:4] == 4'hF) e.resp = 2'b10;
      else begin
        for (int b = 0; b < 4; b++)
          if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        rmem[idx] = cur;
        rmem_vld[idx] = 1'b1;
        e.resp = 2'b00;
      end
    end else begin
      e.resp  = (a[7:4] == 4'hF) ? 2'b11 : 2'b00;
      e.rdata = (a[7:4] == 4'hF) ? 32'h0 : cur;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int done_cnt0 = 0, done_cnt1 = 0;
  int cyc = 0, grant_cyc = 0, aw_cyc = 0, w_cyc = 0;
  bit chk_lat = 1'b0;
  logic [31:0] last_araddr = '0;
  int done_order[$];

  initial begin
    bit idle_watch;
    int last_served, exp_grant, idx;
    exp_t e;
    idle_watch = 1'b1; last_served = 1; exp_grant = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        idle_watch = 1'b1; last_served = 1; exp_grant = -1;
      end else begin
        if (arvalid && arready) last_araddr = araddr;
        if (awvalid) aw_cyc++;
        if (wvalid) w_cyc++;
        if (arvalid) chk("arprot", arprot, 3'b000);
        if (awvalid) chk("awprot", awprot, 3'b000);
        if (idle_watch && req_valid != 2'b00) begin
          exp_grant = (req_valid == 2'b11) ? 1 - last_served : (req_valid[1] ? 1 : 0);
          grant_cyc = cyc;
          idle_watch = 1'b0;
        end
        if (req_done != 2'b00) begin
          chk("done_onehot", (req_done == 2'b01 || req_done == 2'b10), 1'b1);
          idx = req_done[1] ? 1 : 0;
          chk("grant_order", idx, exp_grant);
          if (chk_lat) chk("latency", cyc - grant_cyc, 3);
          if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
            chk("done_unexpected", req_done, 2'b00);
          end else begin
            e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk(idx == 0 ? "resp0" : "resp1", req_resp, e.resp);
            if (!e.we) chk(idx == 0 ? "rdata0" : "rdata1", req_rdata, e.rdata);
          end
          last_served = idx;
          idle_watch = 1'b1;
          done_order.push_back(idx);
          if (idx == 0) done_cnt0++; else done_cnt1++;
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic do_req(input int n, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    exp_t e;
    int start, t;
    e = model(w, a, d, s);
    if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    @(posedge clk); #1;
    if (n == 0) begin v0 = 1'b1; we0 = w; a0 = a; d0 = d; s0 = s; start = done_cnt0; end
    else begin v1 = 1'b1; we1 = w; a1 = a; d1 = d; s1 = s; start = done_cnt1; end
    t = 0;
    while (((n == 0) ? done_cnt0 : done_cnt1) == start && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) chk("req_timeout", t, 0);
    if (n == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic req_loop(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic w;
      logic [31:0] a, d;
      logic [3:0] s;
      w = 1'($urandom_range(0, 1));
      a = {22'd0, (n == 0) ? 2'b01 : 2'b10, 6'($urandom_range(0, 63)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(n, w, a, d, s);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, aw0, w0, wr0, dc, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {req_done, arvalid, rready, awvalid, wvalid, bready}, '0);
    chk("rst_addr", {req_rdata, araddr}, '0);
    chk("rst_wr", {awaddr, wdata}, '0);
    chk("rst_misc", {req_resp, wstrb}, '0);

    // contention from reset, zero wait states
    chk_lat = 1'b1;
    base = done_order.size();
    fork
      for (int i = 0; i < 3; i++) do_req(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) do_req(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'h0);
      begin @(posedge clk); #1 rst = 1'b1; end
    join
    for (int i = 0; i < 6; i++)
      chk("alternation", (done_order.size() > base + i) ? done_order[base + i] : -1, i % 2);

    // single read, no wait states
    do_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
    chk("araddr", last_araddr, 32'h4);

    // write with awready two cycles late
    chk_lat = 1'b0;
    aw_dly = 2;
    aw0 = aw_cyc; w0 = w_cyc; wr0 = wr_count;
    do_req(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF);
    chk("awvalid_cycles", aw_cyc - aw0, 3);
    chk("wvalid_cycles", w_cyc - w0, 1);
    chk("write_count", wr_count - wr0, 1);
    aw_dly = 0;
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0);

    // slave error then a normal request
    do_req(0, 1'b1, 32'h1F0, 32'hCAFE_F00D, 4'hF);
    do_req(0, 1'b1, 32'h10C, 32'hA1B2_C3D4, 4'h5);
    do_req(0, 1'b0, 32'h10C, 32'h0, 4'h0);

    // reset while waiting in the read-data phase
    r_dly = 5;
    dc = done_cnt0;
    @(posedge clk); #1;
    v0 = 1'b1; we0 = 1'b0; a0 = 32'h104;
    t = 0;
    do begin @(negedge clk); t++; end while (!rready && t < 50);
    chk("rready_seen", rready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; v0 = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {req_done, arvalid, rready, awvalid, wvalid, bready}, '0);
    chk("midrst_data", {req_rdata, araddr, req_resp}, '0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt0, dc);
    r_dly = 0;
    chk_lat = 1'b1;
    do_req(0, 1'b0, 32'h104, 32'h0, 4'h0);
    chk_lat = 1'b0;

    // randomized traffic with random slave stalls
    rand_mode = 1'b1;
    fork
      req_loop(0, 40);
      req_loop(1, 40);
    join
    repeat (10) @(negedge clk);
    chk("q0_empty", exp_q0.size(), 0);
    chk("q1_empty", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
